// File: rtl/legup_burst_mem_slave.sv
// Avalon-MM burst memory responder: line-fill burst reads, byte-enabled write bursts, fixed read latency.
// Optional random wait-state injection when LEGUP_BURST_SLAVE_STALL_EN is defined.
module legup_burst_mem_slave #(
    parameter int DATA_WIDTH   = 32,
    parameter int BURST_WIDTH  = 3,
    parameter int MEM_WORDS    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [31:0]             avs_address,
    input  logic                    avs_beginbursttransfer,
    input  logic [BURST_WIDTH-1:0]  avs_burstcount,
    input  logic [DATA_WIDTH/8-1:0] avs_byteenable,
    input  logic                    avs_read,
    input  logic                    avs_write,
    input  logic [DATA_WIDTH-1:0]   avs_writedata,
    output logic [DATA_WIDTH-1:0]   avs_readdata,
    output logic                    avs_readdatavalid,
    output logic                    avs_waitrequest
);
    localparam int BE_W = DATA_WIDTH / 8;
    localparam int OW   = $clog2(BE_W);
    localparam int MW   = $clog2(MEM_WORDS);

    typedef enum logic [1:0] {IDLE, READ_BURST, WRITE_BURST} state_t;

    state_t                 state_q, state_d;
    logic [BURST_WIDTH-1:0] rem_q, rem_d, bc_m1;
    logic [MW-1:0]          idx_q, idx_d, addr_idx, wr_idx, rd_idx;
    logic                   wr_en, rd_en, stall, accept;
    logic [DATA_WIDTH-1:0]  wr_word;
    logic [DATA_WIDTH-1:0]  mem [MEM_WORDS];
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    logic [DATA_WIDTH-1:0]  dat_q [READ_LATENCY];
    logic [DATA_WIDTH-1:0]  dat_d [READ_LATENCY];
    logic                   unused_ok;

    assign unused_ok = ^{avs_beginbursttransfer, avs_address};
    assign addr_idx  = avs_address[OW+MW-1:OW];
    // burstcount of zero is served as a single beat
    assign bc_m1     = (avs_burstcount == '0) ? '0 : avs_burstcount - 1'b1;

`ifdef LEGUP_BURST_SLAVE_STALL_EN
    logic [15:0] lfsr_q, lfsr_d;
    always_comb lfsr_d = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    always_ff @(posedge clk) begin
        if (!reset) lfsr_q <= 16'hACE1;
        else        lfsr_q <= lfsr_d;
    end
    assign stall = (lfsr_q[1:0] == 2'b00);
`else
    assign stall = 1'b0;
`endif

    assign avs_waitrequest = !reset || (state_q == READ_BURST) || stall;
    assign accept          = !avs_waitrequest;

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        wr_idx  = addr_idx;
        rd_idx  = addr_idx;
        case (state_q)
            IDLE: begin
                // write wins if a master illegally raises read and write together
                if (accept && avs_write) begin
                    wr_en = 1'b1;
                    rem_d = bc_m1;
                    idx_d = addr_idx + 1'b1;
                    if (bc_m1 != '0) state_d = WRITE_BURST;
                end else if (accept && avs_read) begin
                    rd_en = 1'b1;
                    rem_d = bc_m1;
                    idx_d = addr_idx + 1'b1;
                    if (bc_m1 != '0) state_d = READ_BURST;
                end
            end
            WRITE_BURST: begin
                if (accept && avs_write) begin
                    wr_en  = 1'b1;
                    wr_idx = idx_q;
                    idx_d  = idx_q + 1'b1;
                    rem_d  = rem_q - 1'b1;
                    if (rem_q == BURST_WIDTH'(1)) state_d = IDLE;
                end
            end
            READ_BURST: begin
                rd_en  = 1'b1;
                rd_idx = idx_q;
                idx_d  = idx_q + 1'b1;
                rem_d  = rem_q - 1'b1;
                if (rem_q == BURST_WIDTH'(1)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        for (int b = 0; b < BE_W; b++)
            wr_word[8*b +: 8] = avs_byteenable[b] ? avs_writedata[8*b +: 8] : mem[wr_idx][8*b +: 8];
    end

    // wr_en already implies reset is high, since waitrequest blocks acceptance in reset
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_idx] <= wr_word;
    end

    always_comb begin
        vld_d[0] = rd_en;
        dat_d[0] = mem[rd_idx];
        for (int k = 1; k < READ_LATENCY; k++) begin
            vld_d[k] = vld_q[k-1];
            dat_d[k] = dat_q[k-1];
        end
        // output stage holds the last returned beat
        if (!vld_d[READ_LATENCY-1]) dat_d[READ_LATENCY-1] = dat_q[READ_LATENCY-1];
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            rem_q   <= '0;
            idx_q   <= '0;
            vld_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < READ_LATENCY; k++) dat_q[k] <= dat_d[k];
        if (!reset) dat_q[READ_LATENCY-1] <= '0;
    end

    assign avs_readdata      = dat_q[READ_LATENCY-1];
    assign avs_readdatavalid = vld_q[READ_LATENCY-1];
endmodule
